switch_allocator: RTL and testbench

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

---
 rtl/switch_allocator.sv | 119 +++++++++++
 tb/tb_switch_allocator.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator: per-input round-robin VC pick, then per-output
// round-robin input pick. Grants are combinational; only the arbiter pointers are registered.
package noc_params;
  localparam int VC_NUM  = 2;
  localparam int VC_SIZE = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  typedef enum logic [2:0] {LOCAL = 3'd0, NORTH = 3'd1, SOUTH = 3'd2, WEST = 3'd3, EAST = 3'd4} port_t;
endpackage

module switch_allocator
  import noc_params::*;
#(
  parameter  int PORT_NUM = 5,
  localparam int PS       = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0]              request_i,
  input  port_t [PORT_NUM-1:0][VC_NUM-1:0]              out_port_i,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc_i,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0]              on_off_i,
  output logic  [PORT_NUM-1:0]                          valid_sel_o,
  output logic  [PORT_NUM-1:0][VC_SIZE-1:0]             vc_sel_o,
  output logic  [PORT_NUM-1:0]                          xbar_valid_o,
  output logic  [PORT_NUM-1:0][PS-1:0]                  xbar_sel_o
);

  logic [PORT_NUM-1:0][VC_SIZE-1:0] in_ptr_q, in_ptr_d;
  logic [PORT_NUM-1:0][PS-1:0]      out_ptr_q, out_ptr_d;

  logic [PORT_NUM-1:0][VC_NUM-1:0]  elig;
  logic [PORT_NUM-1:0]              cand_vld;
  logic [PORT_NUM-1:0][VC_SIZE-1:0] cand_vc;
  port_t [PORT_NUM-1:0]             cand_port;

  logic [PORT_NUM-1:0]              gnt_in;
  logic [PORT_NUM-1:0][VC_SIZE-1:0] gnt_vc;
  logic [PORT_NUM-1:0]              gnt_out;
  logic [PORT_NUM-1:0][PS-1:0]      gnt_sel;

  // Out-of-range port or VC ids are never eligible rather than indexing past the arrays.
  always_comb begin
    elig = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (request_i[p][v] && (int'(out_port_i[p][v]) < PORT_NUM) &&
            (int'(downstream_vc_i[p][v]) < VC_NUM))
          elig[p][v] = on_off_i[out_port_i[p][v]][downstream_vc_i[p][v]];
      end
    end
  end

  always_comb begin
    int v;
    cand_vld  = '0;
    cand_vc   = '0;
    cand_port = {PORT_NUM{LOCAL}};
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int k = 0; k < VC_NUM; k++) begin
        v = int'(in_ptr_q[p]) + k;
        if (v >= VC_NUM) v = v - VC_NUM;
        if (!cand_vld[p] && elig[p][v]) begin
          cand_vld[p]  = 1'b1;
          cand_vc[p]   = VC_SIZE'(v);
          cand_port[p] = out_port_i[p][v];
        end
      end
    end
  end

  // A losing candidate is not replaced by the input's next VC; it simply waits.
  always_comb begin
    int i;
    gnt_in  = '0;
    gnt_vc  = '0;
    gnt_out = '0;
    gnt_sel = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int k = 0; k < PORT_NUM; k++) begin
        i = int'(out_ptr_q[o]) + k;
        if (i >= PORT_NUM) i = i - PORT_NUM;
        if (!gnt_out[o] && cand_vld[i] && (int'(cand_port[i]) == o)) begin
          gnt_out[o] = 1'b1;
          gnt_sel[o] = PS'(i);
          gnt_in[i]  = 1'b1;
          gnt_vc[i]  = cand_vc[i];
        end
      end
    end
  end

  always_comb begin
    in_ptr_d  = in_ptr_q;
    out_ptr_d = out_ptr_q;
    for (int p = 0; p < PORT_NUM; p++) begin
      if (gnt_in[p])
        in_ptr_d[p] = (int'(gnt_vc[p]) + 1 == VC_NUM) ? '0 : gnt_vc[p] + 1'b1;
    end
    for (int o = 0; o < PORT_NUM; o++) begin
      if (gnt_out[o])
        out_ptr_d[o] = (int'(gnt_sel[o]) + 1 == PORT_NUM) ? '0 : gnt_sel[o] + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ptr_q  <= '0;
      out_ptr_q <= '0;
    end else begin
      in_ptr_q  <= in_ptr_d;
      out_ptr_q <= out_ptr_d;
    end
  end

  assign valid_sel_o  = rst ? '0 : gnt_in;
  assign vc_sel_o     = rst ? '0 : gnt_vc;
  assign xbar_valid_o = rst ? '0 : gnt_out;
  assign xbar_sel_o   = rst ? '0 : gnt_sel;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: stimulus pushes expected grants into a scoreboard,
// a negedge monitor pops and compares them against the live outputs.
module tb_switch_allocator;
  import noc_params::*;

  localparam int P  = 5;
  localparam int PS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic  [P-1:0][VC_NUM-1:0]              request;
  port_t [P-1:0][VC_NUM-1:0]              out_port;
  logic  [P-1:0][VC_NUM-1:0][VC_SIZE-1:0] dvc;
  logic  [P-1:0][VC_NUM-1:0]              on_off;
  logic  [P-1:0]                          valid_sel;
  logic  [P-1:0][VC_SIZE-1:0]             vc_sel;
  logic  [P-1:0]                          xbar_valid;
  logic  [P-1:0][PS-1:0]                  xbar_sel;

  typedef struct {
    string                 name;
    logic [P-1:0]          vs;
    logic [P*VC_SIZE-1:0]  vc;
    logic [P-1:0]          xv;
    logic [P*PS-1:0]       xs;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_chk  = 0;
  int   n_pass = 0;

  switch_allocator #(.PORT_NUM(P)) dut (
    .clk            (clk),
    .rst            (rst),
    .request_i      (request),
    .out_port_i     (out_port),
    .downstream_vc_i(dvc),
    .on_off_i       (on_off),
    .valid_sel_o    (valid_sel),
    .vc_sel_o       (vc_sel),
    .xbar_valid_o   (xbar_valid),
    .xbar_sel_o     (xbar_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s actual=%h required=%h", name, fld, act, req);
  endtask

  // Monitor: one scoreboard entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      $display("txn %-12s valid_sel=%b vc_sel=%b xbar_valid=%b xbar_sel=%h",
               e.name, valid_sel, vc_sel, xbar_valid, xbar_sel);
      chk(e.name, "valid_sel",  32'(valid_sel),  32'(e.vs));
      chk(e.name, "vc_sel",     32'(vc_sel),     32'(e.vc));
      chk(e.name, "xbar_valid", 32'(xbar_valid), 32'(e.xv));
      chk(e.name, "xbar_sel",   32'(xbar_sel),   32'(e.xs));
    end
  end

  task automatic clear_inputs();
    request = '0;
    dvc     = '0;
    on_off  = '1;
    for (int p = 0; p < P; p++)
      for (int v = 0; v < VC_NUM; v++)
        out_port[p][v] = LOCAL;
  endtask

  task automatic clear_exp();
    cur.vs = '0;
    cur.vc = '0;
    cur.xv = '0;
    cur.xs = '0;
  endtask

  task automatic gnt(input int p, input int v, input int o);
    cur.vs[p] = 1'b1;
    cur.vc[p*VC_SIZE +: VC_SIZE] = VC_SIZE'(v);
    cur.xv[o] = 1'b1;
    cur.xs[o*PS +: PS] = PS'(p);
  endtask

  task automatic step(input string name);
    cur.name = name;
    sb.push_back(cur);
    @(posedge clk);
    #1;
    clear_exp();
  endtask

  // Asynchronous reset with inputs still active: outputs must be forced low.
  task automatic reset_pulse();
    rst = 1'b1;
    clear_exp();
    step("rst_mid");
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    clear_exp();
    request = '1;
    @(posedge clk);
    #1;

    step("rst_hold");
    rst = 1'b0;
    gnt(0, 0, 0); step("rst_release");
    reset_pulse();

    // Single request, input 1 VC1 -> EAST
    request[1][1] = 1'b1; out_port[1][1] = EAST;
    gnt(1, 1, 4); step("single");
    reset_pulse();

    // VC fairness at input 0
    request[0] = 2'b11;
    gnt(0, 0, 0); step("vcfair0");
    gnt(0, 1, 0); step("vcfair1");
    gnt(0, 0, 0); step("vcfair2");
    gnt(0, 1, 0); step("vcfair3");
    reset_pulse();

    // Output conflict at LOCAL among inputs 1,2,3
    request[1][0] = 1'b1; request[2][0] = 1'b1; request[3][0] = 1'b1;
    gnt(1, 0, 0); step("conflict0");
    gnt(2, 0, 0); step("conflict1");
    gnt(3, 0, 0); step("conflict2");
    gnt(1, 0, 0); step("conflict3");
    reset_pulse();

    // Flow control on EAST VC0, then a U-turn at SOUTH VC1
    request[0][0] = 1'b1; out_port[0][0] = EAST; on_off[4][0] = 1'b0;
    step("stopped");
    on_off[4][0] = 1'b1;
    gnt(0, 0, 4); step("resumed");
    request[0][0] = 1'b0;
    request[2][1] = 1'b1; out_port[2][1] = SOUTH; dvc[2][1] = 1'b1;
    gnt(2, 1, 2); step("uturn");
    reset_pulse();

    // Parallel non-conflicting grants
    request[0][0] = 1'b1; out_port[0][0] = NORTH;
    request[1][0] = 1'b1; out_port[1][0] = SOUTH;
    request[2][0] = 1'b1; out_port[2][0] = WEST;
    gnt(0, 0, 1); gnt(1, 0, 2); gnt(2, 0, 3); step("parallel");
    reset_pulse();

    // Stage-2 loser gets nothing and keeps its VC pointer
    request[0][0] = 1'b1;
    request[1][0] = 1'b1;
    request[1][1] = 1'b1; out_port[1][1] = NORTH;
    gnt(0, 0, 0); step("loser0");
    gnt(1, 0, 0); step("loser1");
    reset_pulse();

    repeat (3) @(negedge clk);
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
